// File: rtl/mold_pkg.sv
// Shared widths, assembly state and record layout for the MoldUDP64 message
// assembler and its output slot.
package mold_pkg;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_KEEP_W = AXI_DATA_W / 8;
    localparam int ML_W       = 16;
    localparam int SID_W      = 80;
    localparam int SEQ_NUM_W  = 64;
    localparam int MSG_MAX_B  = 64;
    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        IDLE,
        ASM
    } asm_state_t;

    typedef struct packed {
        logic [8*MSG_MAX_B-1:0] data;
        logic [ML_W-1:0]        len;
        logic                   trunc;
        logic [SID_W-1:0]       sid;
        logic [SEQ_NUM_W-1:0]   seq_num;
    } mold_rec_t;
endpackage

// File: rtl/mold_msg_obuf.sv
// Single-entry record slot with valid/ready; a load is accepted when the slot
// is empty or draining this cycle, otherwise it is flagged as dropped.
module mold_msg_obuf
    import mold_pkg::*;
(
    input  logic      clk,
    input  logic      nreset,
    input  logic      load,
    input  mold_rec_t rec_in,
    input  logic      ready,
    output logic      vld,
    output mold_rec_t rec,
    output logic      drop
);
    logic      vld_p1;
    mold_rec_t rec_p1;
    logic      take;

    assign take = !vld_p1 || ready;
    assign drop = load && !take;

    // slot register
    always_ff @(posedge clk) begin
        if (nreset) begin
            vld_p1 <= 1'b0;
            rec_p1 <= '0;
        end else if (load && take) begin
            vld_p1 <= 1'b1;
            rec_p1 <= rec_in;
        end else if (vld_p1 && ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign vld = vld_p1;
    assign rec = rec_p1;
endmodule

// File: rtl/mold_msg_asm.sv
// Assembles the parser's per-beat message stream into byte-0-aligned records
// and hands them to the decoder through a one-entry slot with counted drops.
module mold_msg_asm
    import mold_pkg::*;
(
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    mold_msg_v_i,
    input  logic                    mold_msg_start_i,
    input  logic [ML_W-1:0]         mold_msg_len_i,
    input  logic [SID_W-1:0]        mold_msg_sid_i,
    input  logic [SEQ_NUM_W-1:0]    mold_msg_seq_num_i,
    input  logic [AXI_KEEP_W-1:0]   mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0]   mold_msg_data_i,
    output logic                    msg_v_o,
    input  logic                    msg_ready_i,
    output logic [8*MSG_MAX_B-1:0]  msg_data_o,
    output logic [ML_W-1:0]         msg_len_o,
    output logic                    msg_trunc_o,
    output logic [SID_W-1:0]        msg_sid_o,
    output logic [SEQ_NUM_W-1:0]    msg_seq_num_o,
    output logic                    proto_err_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);
    localparam int KW    = $clog2(AXI_KEEP_W);
    localparam int MSG_W = 8 * MSG_MAX_B;

    asm_state_t             state;
    logic [ML_W-1:0]        cnt, len_r, base, len_eff, cnt_n;
    logic [SID_W-1:0]       sid_r;
    logic [SEQ_NUM_W-1:0]   seq_r;
    logic [MSG_W-1:0]       asm_buf, asm_buf_n;
    logic [KW:0]            n_bytes;
    logic                   start, cont, beat, complete, err_c, drop;
    logic                   proto_err_r;
    logic [DROP_CNT_W-1:0]  drop_cnt_r;
    mold_rec_t              rec_n, rec_q;

    function automatic logic [ML_W-1:0] sat_add_cnt(input logic [ML_W-1:0] a,
                                                     input logic [KW:0] b);
        logic [ML_W:0] s;
        s = {1'b0, a} + {{(ML_W-KW){1'b0}}, b};
        return s[ML_W] ? {ML_W{1'b1}} : s[ML_W-1:0];
    endfunction

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] a);
        return (&a) ? a : a + DROP_CNT_W'(1);
    endfunction

    always_comb begin
        n_bytes = '0;
        for (int i = 0; i < AXI_KEEP_W; i++)
            n_bytes = n_bytes + (KW+1)'(mold_msg_mask_i[i]);
    end

    assign start    = mold_msg_v_i && mold_msg_start_i;
    assign cont     = mold_msg_v_i && !mold_msg_start_i && (state == ASM);
    assign beat     = start || cont;
    assign err_c    = (start && state == ASM) ||
                      (mold_msg_v_i && !mold_msg_start_i && state == IDLE);
    assign base     = start ? '0 : cnt;
    assign len_eff  = start ? mold_msg_len_i : len_r;
    assign cnt_n    = sat_add_cnt(base, n_bytes);
    assign complete = beat && (cnt_n >= len_eff);

    // Each stored byte k takes beat lane k-base; lanes past the mask, the
    // message length or the buffer end never land.
    always_comb begin
        asm_buf_n = start ? '0 : asm_buf;
        for (int k = 0; k < MSG_MAX_B; k++) begin
            int signed rel;
            rel = k - int'(base);
            if (beat && rel >= 0 && rel < int'(n_bytes) && k < int'(len_eff))
                asm_buf_n[8*k +: 8] = mold_msg_data_i[{rel[KW-1:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        rec_n.data    = asm_buf_n;
        rec_n.len     = len_eff;
        rec_n.trunc   = len_eff > ML_W'(MSG_MAX_B);
        rec_n.sid     = start ? mold_msg_sid_i : sid_r;
        rec_n.seq_num = start ? mold_msg_seq_num_i : seq_r;
    end

    // assembly state
    always_ff @(posedge clk) begin
        if (nreset) begin
            state       <= IDLE;
            cnt         <= '0;
            len_r       <= '0;
            sid_r       <= '0;
            seq_r       <= '0;
            asm_buf     <= '0;
            proto_err_r <= 1'b0;
            drop_cnt_r  <= '0;
        end else begin
            proto_err_r <= err_c;
            if (beat) begin
                asm_buf <= asm_buf_n;
                cnt     <= cnt_n;
                state   <= complete ? IDLE : ASM;
            end
            if (start) begin
                len_r <= mold_msg_len_i;
                sid_r <= mold_msg_sid_i;
                seq_r <= mold_msg_seq_num_i;
            end
            if (drop)
                drop_cnt_r <= sat_inc(drop_cnt_r);
        end
    end

    mold_msg_obuf u_obuf (
        .clk    (clk),
        .nreset (nreset),
        .load   (complete),
        .rec_in (rec_n),
        .ready  (msg_ready_i),
        .vld    (msg_v_o),
        .rec    (rec_q),
        .drop   (drop)
    );

    assign msg_data_o    = rec_q.data;
    assign msg_len_o     = rec_q.len;
    assign msg_trunc_o   = rec_q.trunc;
    assign msg_sid_o     = rec_q.sid;
    assign msg_seq_num_o = rec_q.seq_num;
    assign proto_err_o   = proto_err_r;
    assign drop_cnt_o    = drop_cnt_r;
endmodule

// File: tb/tb_mold_msg_asm.sv
// Bench for mold_msg_asm: vector table, directed corner sequences and random
// traffic against a message-level reference model.
module tb_mold_msg_asm;
    logic         clk = 1'b0;
    logic         nreset;
    logic         v, st, ready;
    logic [15:0]  len_i;
    logic [79:0]  sid_i;
    logic [63:0]  seq_i;
    logic [7:0]   mask;
    logic [63:0]  data;
    logic         msg_v, msg_trunc, proto_err;
    logic [511:0] msg_data;
    logic [15:0]  msg_len, drop_cnt;
    logic [79:0]  msg_sid;
    logic [63:0]  msg_seq;

    always #5 clk = ~clk;

    mold_msg_asm dut (
        .clk                (clk),
        .nreset             (nreset),
        .mold_msg_v_i       (v),
        .mold_msg_start_i   (st),
        .mold_msg_len_i     (len_i),
        .mold_msg_sid_i     (sid_i),
        .mold_msg_seq_num_i (seq_i),
        .mold_msg_mask_i    (mask),
        .mold_msg_data_i    (data),
        .msg_v_o            (msg_v),
        .msg_ready_i        (ready),
        .msg_data_o         (msg_data),
        .msg_len_o          (msg_len),
        .msg_trunc_o        (msg_trunc),
        .msg_sid_o          (msg_sid),
        .msg_seq_num_o      (msg_seq),
        .proto_err_o        (proto_err),
        .drop_cnt_o         (drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: message bytes by offset, plus the output slot.
    bit           m_in;
    int           m_cnt, m_len, m_drop;
    logic [79:0]  m_sid;
    logic [63:0]  m_seq;
    logic [7:0]   mb[64];
    bit           m_sv, m_err, m_rtr;
    logic [511:0] m_data;
    logic [15:0]  m_rlen;
    logic [79:0]  m_rsid;
    logic [63:0]  m_rseq;

    task automatic model_edge();
        bit comp = 0;
        bit add  = 0;
        int n    = 0;
        if (nreset) begin
            m_in = 0; m_cnt = 0; m_len = 0; m_drop = 0; m_sv = 0; m_err = 0;
            m_data = '0; m_rlen = '0; m_rtr = 0; m_rsid = '0; m_rseq = '0;
            return;
        end
        m_err = 0;
        if (v) begin
            for (int i = 0; i < 8; i++) n += int'(mask[i]);
            if (st) begin
                if (m_in) m_err = 1;
                m_len = int'(len_i); m_sid = sid_i; m_seq = seq_i; m_cnt = 0;
                foreach (mb[k]) mb[k] = 8'h00;
                add = 1;
            end else if (!m_in) begin
                m_err = 1;
            end else begin
                add = 1;
            end
        end
        if (add) begin
            for (int j = 0; j < n; j++)
                if (m_cnt + j < m_len && m_cnt + j < 64) mb[m_cnt + j] = data[8*j +: 8];
            m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
            comp  = (m_cnt >= m_len);
            m_in  = !comp;
        end
        if (comp) begin
            if (!m_sv || ready) begin
                m_sv = 1; m_rlen = 16'(m_len); m_rtr = (m_len > 64);
                m_rsid = m_sid; m_rseq = m_seq;
                for (int k = 0; k < 64; k++) m_data[8*k +: 8] = (k < m_len) ? mb[k] : 8'h00;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else if (m_sv && ready) begin
            m_sv = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("vld", 512'(msg_v), 512'(m_sv));
        if (m_sv) begin
            check("data", msg_data, m_data);
            check("len", 512'(msg_len), 512'(m_rlen));
            check("trunc", 512'(msg_trunc), 512'(m_rtr));
            check("sid", 512'(msg_sid), 512'(m_rsid));
            check("seq", 512'(msg_seq), 512'(m_rseq));
        end
        check("proto_err", 512'(proto_err), 512'(m_err));
        check("drop_cnt", 512'(drop_cnt), 512'(m_drop));
    endtask

    task automatic beat(input bit s, input logic [15:0] l, input logic [7:0] mk, input logic [63:0] d);
        v = 1'b1; st = s; len_i = l; mask = mk; data = d;
        step();
    endtask

    task automatic idle();
        v = 1'b0; st = 1'b0; mask = '0; data = '0;
        step();
    endtask

    task automatic do_reset();
        v = 1'b0; st = 1'b0; nreset = 1'b1;
        step();
        nreset = 1'b0;
    endtask

    function automatic logic [7:0] mk_mask(input int n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    typedef struct {
        logic [15:0] len;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;
    vec_t vt[5];

    logic [511:0] exp_d;
    int           gleft, r, n;

    initial begin
        vt[0] = '{16'd8, 8'hFF, 64'h0102030405060708, 64'h0102030405060708};
        vt[1] = '{16'd3, 8'hFF, 64'h1122334455667788, 64'h0000000000667788};
        vt[2] = '{16'd0, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};
        vt[3] = '{16'd5, 8'h1F, 64'hAABBCCDDEEFF0011, 64'h000000DDEEFF0011};
        vt[4] = '{16'd4, 8'h0F, 64'h9988776655443322, 64'h0000000055443322};

        nreset = 1'b0; v = 1'b0; st = 1'b0; ready = 1'b1;
        len_i = '0; mask = '0; data = '0;
        sid_i = 80'hDEADBEEF; seq_i = 64'hF0F0F0F0F0F0F0F0;
        do_reset();
        idle();
        check("rst_vld", 512'(msg_v), 512'(0));
        check("rst_data", msg_data, 512'(0));
        check("rst_len", 512'(msg_len), 512'(0));
        check("rst_sid", 512'(msg_sid), 512'(0));
        check("rst_drop", 512'(drop_cnt), 512'(0));
        check("rst_err", 512'(proto_err), 512'(0));

        for (int i = 0; i < 5; i++) begin
            beat(1'b1, vt[i].len, vt[i].mask, vt[i].data);
            check("tbl_vld", 512'(msg_v), 512'(1));
            check("tbl_data", msg_data, 512'(vt[i].exp));
            check("tbl_len", 512'(msg_len), 512'(vt[i].len));
            idle();
        end

        // two full beats, len 16
        beat(1'b1, 16'd16, 8'hFF, {16{4'hA}});
        check("tp1_early", 512'(msg_v), 512'(0));
        beat(1'b0, 16'd16, 8'hFF, {16{4'hB}});
        check("tp1_vld", 512'(msg_v), 512'(1));
        check("tp1_data", msg_data, 512'({{16{4'hB}}, {16{4'hA}}}));
        check("tp1_sid", 512'(msg_sid), 512'(80'hDEADBEEF));
        check("tp1_seq", 512'(msg_seq), 512'(64'hF0F0F0F0F0F0F0F0));
        idle();

        // len 11, last beat mask 0F: fourth lane ignored
        beat(1'b1, 16'd11, 8'hFF, 64'h0706050403020100);
        beat(1'b0, 16'd11, 8'h0F, 64'hA0A1A2A3B0B1B2B3);
        check("tp2_data", msg_data, 512'({40'h0, 24'hB1B2B3, 64'h0706050403020100}));
        check("tp2_len", 512'(msg_len), 512'(11));
        idle();

        // len 0 completes on its start beat; FSM then idle, so a stray beat errs
        beat(1'b1, 16'd0, 8'h00, 64'h0);
        check("tp3_vld", 512'(msg_v), 512'(1));
        check("tp3_data", msg_data, 512'(0));
        beat(1'b0, 16'd0, 8'hFF, 64'h1234);
        check("tp3_err", 512'(proto_err), 512'(1));
        idle();

        // len 80: truncated to first 8 beats
        for (int i = 0; i < 10; i++) beat(i == 0, 16'd80, 8'hFF, {8{8'(i + 1)}});
        for (int k = 0; k < 64; k++) exp_d[8*k +: 8] = 8'(k / 8 + 1);
        check("tp4_vld", 512'(msg_v), 512'(1));
        check("tp4_trunc", 512'(msg_trunc), 512'(1));
        check("tp4_len", 512'(msg_len), 512'(80));
        check("tp4_data", msg_data, exp_d);
        idle();

        // backpressure: second record dropped, third reloads on handshake
        ready = 1'b0;
        beat(1'b1, 16'd8, 8'hFF, {8{8'h11}});
        beat(1'b1, 16'd8, 8'hFF, {8{8'h22}});
        check("bp_drop", 512'(drop_cnt), 512'(1));
        check("bp_hold", msg_data, 512'({8{8'h11}}));
        idle();
        check("bp_stable", msg_data, 512'({8{8'h11}}));
        ready = 1'b1;
        beat(1'b1, 16'd8, 8'hFF, {8{8'h33}});
        check("bp_reload", msg_data, 512'({8{8'h33}}));
        check("bp_nodrop", 512'(drop_cnt), 512'(1));
        idle();
        check("bp_empty", 512'(msg_v), 512'(0));

        // protocol errors
        do_reset();
        beat(1'b0, 16'd8, 8'hFF, 64'h55);
        check("err_stray", 512'(proto_err), 512'(1));
        check("err_norec", 512'(msg_v), 512'(0));
        beat(1'b1, 16'd16, 8'hFF, 64'h66);
        beat(1'b1, 16'd8, 8'hFF, 64'h0123456789ABCDEF);
        check("err_abort", 512'(proto_err), 512'(1));
        check("err_len8", 512'(msg_len), 512'(8));
        check("err_data", msg_data, 512'(64'h0123456789ABCDEF));
        idle();

        // reset mid-message discards the partial record
        beat(1'b1, 16'd40, 8'hFF, 64'h77);
        do_reset();
        beat(1'b0, 16'd40, 8'hFF, 64'h88);
        check("rstmid_err", 512'(proto_err), 512'(1));
        check("rstmid_norec", 512'(msg_v), 512'(0));
        idle();

        // random traffic
        gleft = 0;
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            sid_i = {16'($urandom()), $urandom(), $urandom()};
            seq_i = {$urandom(), $urandom()};
            data  = {$urandom(), $urandom()};
            r = int'($urandom_range(0, 99));
            n = int'($urandom_range(0, 8));
            mask = mk_mask(n);
            v = 1'b1;
            if (r < 15) begin
                v = 1'b0; st = 1'b0;
            end else if (r < 18 && gleft <= 0) begin
                st = 1'b0;
            end else if (r < 21 || gleft <= 0) begin
                st = 1'b1;
                len_i = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 8))
                                                     : 16'($urandom_range(0, 90));
                gleft = int'(len_i) - n;
            end else begin
                st = 1'b0;
                gleft -= n;
            end
            step();
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
